// File: rtl/video_regs_if.sv
// CPU register-window bus for the video register block.
interface video_regs_if;
    logic        cs;
    logic        write;
    logic        rd;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;

    modport master (
        output cs, write, rd, addr, wdata,
        input  rdata
    );

    modport slave (
        input  cs, write, rd, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/video_regs.sv
// Sprite shadow/active registers, frame status, frame counter and
// sprite animation sequencer behind a small CPU register window.
module video_regs #(
    parameter int CORDW    = 16,
    parameter int ANIM_LEN = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    video_regs_if.slave             bus,
    input  logic                    frame,
    input  logic                    vsync,
    output logic signed [CORDW-1:0] sprx,
    output logic signed [CORDW-1:0] spry,
    output logic                    spr_en,
    output logic [1:0]              anim_frame,
    output logic                    irq
);
    localparam int CW = $clog2(ANIM_LEN);
    localparam logic [CW-1:0] C_LAST = CW'(ANIM_LEN - 1);
    localparam logic [CW-1:0] C_Q1   = CW'(ANIM_LEN / 4 - 1);
    localparam logic [CW-1:0] C_HALF = CW'(ANIM_LEN / 2 - 1);
    localparam logic [CW-1:0] C_Q3   = CW'(3 * ANIM_LEN / 4 - 1);

    typedef enum logic {MANUAL, RUN} anim_e;

    logic [CORDW-1:0] sx_sh;
    logic [CORDW-1:0] sy_sh;
    logic [5:0]       ctrl_sh;
    logic [5:0]       ctrl_act;
    logic             flag;
    logic [15:0]      fcnt;
    anim_e            state;
    anim_e            state_d;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_d;
    logic [1:0]       run_fr;
    logic [1:0]       run_fr_d;
    logic             wr;
    logic             clr;

    assign wr  = bus.cs && bus.write;
    assign clr = bus.cs && bus.rd && (bus.addr == 12'h003);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_sh   <= '0;
            sy_sh   <= '0;
            ctrl_sh <= '0;
        end else if (wr) begin
            case (bus.addr)
                12'h000: sx_sh   <= CORDW'(bus.wdata);
                12'h001: sy_sh   <= CORDW'(bus.wdata);
                12'h002: ctrl_sh <= {bus.wdata[5:4], 1'b0, bus.wdata[2:0]};
                default: ;
            endcase
        end
    end

    // Active copies sample the shadows before any same-cycle write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sprx     <= '0;
            spry     <= '0;
            ctrl_act <= '0;
            fcnt     <= '0;
        end else if (frame) begin
            sprx     <= sx_sh;
            spry     <= sy_sh;
            ctrl_act <= ctrl_sh;
            fcnt     <= fcnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag <= 1'b0;
            irq  <= 1'b0;
        end else begin
            irq <= flag && ctrl_act[2];
            if (frame)
                flag <= 1'b1;
            else if (clr)
                flag <= 1'b0;
        end
    end

    function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] c);
        return (c == C_LAST) ? '0 : c + 1'b1;
    endfunction

    function automatic logic [1:0] sched(
        input logic [CW-1:0] c,
        input logic [1:0]    cur
    );
        if (c == '0)          return 2'd0;
        else if (c == C_Q1)   return 2'd1;
        else if (c == C_HALF) return 2'd0;
        else if (c == C_Q3)   return 2'd2;
        else                  return cur;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MANUAL;
            cnt    <= '0;
            run_fr <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            run_fr <= run_fr_d;
        end
    end

    // Mode changes follow the anim_run bit that was active before this frame.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        run_fr_d = run_fr;
        if (frame) begin
            unique case (state)
                MANUAL: begin
                    if (ctrl_act[1]) begin
                        state_d  = RUN;
                        run_fr_d = sched('0, run_fr);
                        cnt_d    = next_cnt('0);
                    end
                end
                RUN: begin
                    if (!ctrl_act[1]) begin
                        state_d = MANUAL;
                    end else begin
                        run_fr_d = sched(cnt, run_fr);
                        cnt_d    = next_cnt(cnt);
                    end
                end
            endcase
        end
    end

    assign spr_en     = ctrl_act[0];
    assign anim_frame = (state == RUN) ? run_fr :
                        (ctrl_act[5:4] == 2'd3) ? 2'd2 : ctrl_act[5:4];

    always_comb begin
        bus.rdata = 16'h0000;
        case (bus.addr)
            12'h000: bus.rdata = 16'(sx_sh);
            12'h001: bus.rdata = 16'(sy_sh);
            12'h002: bus.rdata = {10'd0, ctrl_sh};
            12'h003: bus.rdata = {14'd0, vsync, flag};
            12'h004: bus.rdata = fcnt;
            default: bus.rdata = 16'h0000;
        endcase
    end
endmodule
